// File: rtl/regfile_seq_pkg.sv
// Shared types for the register-file op sequencer: op codes, FSM states, default widths.
package regfile_seq_pkg;

    localparam int unsigned DefaultDw = 16;
    localparam int unsigned DefaultAw = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MOV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRdA  = 2'b01,
        StRdB  = 2'b10,
        StWb   = 2'b11
    } state_e;

    // MOV only consumes operand A, so its read of B is skipped.
    function automatic logic op_reads_b(input op_e op);
        return op != OP_MOV;
    endfunction

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/MOV with zero, negative and signed overflow.
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
) (
    input  op_e           i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_y,
    output logic          o_z,
    output logic          o_n,
    output logic          o_v
);

    logic [DW-1:0] w_b_add;
    logic [DW-1:0] w_cin;
    logic [DW-1:0] w_sum;
    logic          w_add_ovf;

    // SUB is a + ~b + 1 so both arithmetic ops share one adder and one overflow rule.
    always_comb begin
        w_b_add   = (i_op == OP_SUB) ? ~i_b : i_b;
        w_cin     = {{(DW-1){1'b0}}, (i_op == OP_SUB)};
        w_sum     = i_a + w_b_add + w_cin;
        w_add_ovf = (i_a[DW-1] == w_b_add[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
    end

    always_comb begin
        o_y = '0;
        o_v = 1'b0;
        unique case (i_op)
            OP_ADD, OP_SUB: begin
                o_y = w_sum;
                o_v = w_add_ovf;
            end
            OP_AND: o_y = i_a & i_b;
            OP_MOV: o_y = i_a;
            default: o_y = '0;
        endcase
        o_z = (o_y == '0);
        o_n = o_y[DW-1];
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Sole master of the register-file port: reads Ra/Rb serially through the single read port,
// computes Rd = Ra op Rb, writes Rd back and pulses done with the result and flags.
module regfile_op_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DW = DefaultDw,
    parameter int unsigned AW = DefaultAw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [1:0]    i_req_op,
    input  logic [AW-1:0] i_req_ra,
    input  logic [AW-1:0] i_req_rb,
    input  logic [AW-1:0] i_req_rd,
    output logic [AW-1:0] o_rf_readnum,
    input  logic [DW-1:0] i_rf_rdata,
    output logic [AW-1:0] o_rf_writenum,
    output logic          o_rf_write,
    output logic [DW-1:0] o_rf_wdata,
    output logic          o_done,
    output logic [DW-1:0] o_result,
    output logic          o_flag_z,
    output logic          o_flag_n,
    output logic          o_flag_v
);

    state_e        r_state;
    op_e           r_op;
    logic [AW-1:0] r_ra;
    logic [AW-1:0] r_rb;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_opa;
    logic [DW-1:0] r_opb;
    logic          r_done;
    logic [DW-1:0] r_result;
    logic          r_flag_z;
    logic          r_flag_n;
    logic          r_flag_v;

    logic [DW-1:0] w_alu_y;
    logic          w_alu_z;
    logic          w_alu_n;
    logic          w_alu_v;

    regfile_seq_alu #(
        .DW(DW)
    ) u_alu (
        .i_op(r_op),
        .i_a (r_opa),
        .i_b (r_opb),
        .o_y (w_alu_y),
        .o_z (w_alu_z),
        .o_n (w_alu_n),
        .o_v (w_alu_v)
    );

    assign o_req_ready = (r_state == StIdle);
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_flag_z    = r_flag_z;
    assign o_flag_n    = r_flag_n;
    assign o_flag_v    = r_flag_v;

    // Write strobe is qualified by rst_n so a reset landing on WB never commits.
    always_comb begin
        o_rf_readnum  = '0;
        o_rf_writenum = '0;
        o_rf_write    = 1'b0;
        o_rf_wdata    = '0;
        unique case (r_state)
            StRdA: o_rf_readnum = r_ra;
            StRdB: o_rf_readnum = r_rb;
            StWb: begin
                o_rf_writenum = r_rd;
                o_rf_write    = rst_n;
                o_rf_wdata    = w_alu_y;
            end
            default: o_rf_readnum = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_op     <= OP_ADD;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_v <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_op    <= op_e'(i_req_op);
                        r_ra    <= i_req_ra;
                        r_rb    <= i_req_rb;
                        r_rd    <= i_req_rd;
                        r_state <= StRdA;
                    end
                end
                StRdA: begin
                    r_opa   <= i_rf_rdata;
                    r_state <= op_reads_b(r_op) ? StRdB : StWb;
                end
                StRdB: begin
                    r_opb   <= i_rf_rdata;
                    r_state <= StWb;
                end
                StWb: begin
                    r_result <= w_alu_y;
                    r_flag_z <= w_alu_z;
                    r_flag_n <= w_alu_n;
                    r_flag_v <= w_alu_v;
                    r_done   <= 1'b1;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench: behavioural 8x16 register file plus an arithmetic reference model.
module tb_regfile_op_sequencer;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_ra = '0;
    logic [AW-1:0] req_rb = '0;
    logic [AW-1:0] req_rd = '0;
    logic [AW-1:0] rf_readnum;
    logic [DW-1:0] rf_rdata;
    logic [AW-1:0] rf_writenum;
    logic          rf_write;
    logic [DW-1:0] rf_wdata;
    logic          done;
    logic [DW-1:0] result;
    logic          flag_z;
    logic          flag_n;
    logic          flag_v;

    always #5 clk = ~clk;

    regfile_op_sequencer #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_ra     (req_ra),
        .i_req_rb     (req_rb),
        .i_req_rd     (req_rd),
        .o_rf_readnum (rf_readnum),
        .i_rf_rdata   (rf_rdata),
        .o_rf_writenum(rf_writenum),
        .o_rf_write   (rf_write),
        .o_rf_wdata   (rf_wdata),
        .o_done       (done),
        .o_result     (result),
        .o_flag_z     (flag_z),
        .o_flag_n     (flag_n),
        .o_flag_v     (flag_v)
    );

    // Register file: combinational read, write on clock edge, plus a bench-only port into R0.
    logic [DW-1:0] rf_mem [8];
    logic          rf_clr = 1'b1;
    logic          force_we = 1'b0;
    logic [DW-1:0] force_data = '0;

    assign rf_rdata = rf_mem[rf_readnum];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
        end else begin
            if (rf_write) rf_mem[rf_writenum] <= rf_wdata;
            if (force_we) rf_mem[0] <= force_data;
        end
    end

    typedef struct {
        int          op;
        int          ra;
        int          rb;
        int          rd;
        logic [15:0] y;
        logic        z;
        logic        n;
        logic        v;
        int          t_edge;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_reg [8];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          wb_cnt = 0;
    exp_t        m_e;
    int          m_off;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic on plain signed integers.
    function automatic void model(input int op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] y, output logic z, output logic n,
                                  output logic v);
        int sa;
        int sb;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            0: r = sa + sb;
            1: r = sa - sb;
            2: r = int'(a & b);
            default: r = int'(a);
        endcase
        y = r[15:0];
        z = (y == 16'h0000);
        n = y[15];
        v = (op < 2) && (r > 32767 || r < -32768);
    endfunction

    function automatic logic [15:0] pickval();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return r[15:0];
        endcase
    endfunction

    // Monitor: walks the in-flight op cycle by cycle and scores done against the queue head.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (q.size() > 0) begin
                m_e = q[0];
                m_off = cyc - m_e.t_edge;
                if (done) begin
                    chk("done_latency", m_off + 1, m_e.lat);
                    chk("result", result, m_e.y);
                    chk("flags_znv", {flag_z, flag_n, flag_v}, {m_e.z, m_e.n, m_e.v});
                    chk("wb_once", wb_cnt, 1);
                    chk("ready_in_done", req_ready, 1);
                    void'(q.pop_front());
                    wb_cnt = 0;
                end else if (m_off >= m_e.lat) begin
                    chk("done_timeout", done, 1);
                    void'(q.pop_front());
                    wb_cnt = 0;
                end else begin
                    chk("ready_busy", req_ready, 0);
                    if (m_off == 0) begin
                        chk("rd_a_readnum", rf_readnum, m_e.ra);
                        chk("rd_a_nowrite", rf_write, 0);
                    end else if (m_off == 1 && m_e.op != 3) begin
                        chk("rd_b_readnum", rf_readnum, m_e.rb);
                        chk("rd_b_nowrite", rf_write, 0);
                    end else begin
                        chk("wb_write", rf_write, 1);
                        chk("wb_writenum", rf_writenum, m_e.rd);
                        chk("wb_wdata", rf_wdata, m_e.y);
                        chk("wb_readnum", rf_readnum, 0);
                        if (rf_write) wb_cnt++;
                    end
                end
            end else begin
                chk("idle_nowrite", rf_write, 0);
                chk("idle_nodone", done, 0);
                chk("idle_ready", req_ready, 1);
                chk("idle_readnum", rf_readnum, 0);
            end
        end
    end

    // Call only at #1 after a rising edge; returns the handshake edge number.
    task automatic issue(input int op, input int ra, input int rb, input int rd, output int t_acc);
        logic [15:0] y;
        logic        z;
        logic        n;
        logic        v;
        exp_t        e;
        bit          got;
        req_op    = op[1:0];
        req_ra    = ra[AW-1:0];
        req_rb    = rb[AW-1:0];
        req_rd    = rd[AW-1:0];
        req_valid = 1'b1;
        got       = 1'b0;
        t_acc     = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        t_acc = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(op, ref_reg[ra], ref_reg[rb], y, z, n, v);
        e.op = op;
        e.ra = ra;
        e.rb = rb;
        e.rd = rd;
        e.y = y;
        e.z = z;
        e.n = n;
        e.v = v;
        e.t_edge = t_acc;
        e.lat = (op == 3) ? 3 : 4;
        q.push_back(e);
        ref_reg[rd] = y;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (q.size() > 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic force_r0(input logic [15:0] val);
        force_data = val;
        force_we   = 1'b1;
        @(posedge clk);
        #1;
        force_we   = 1'b0;
        ref_reg[0] = val;
    endtask

    initial begin
        int t1;
        int t2;
        int t3;
        int td;
        int gap;
        for (int i = 0; i < 8; i++) ref_reg[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rf_clr = 1'b0;
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_z, flag_n, flag_v}, 3'b000);
        chk("rst_ready", req_ready, 1);
        chk("rst_write", rf_write, 0);
        chk("rst_readnum", rf_readnum, 0);
        chk("rst_wdata", rf_wdata, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Preload R1=5, R2=3 through R0, then ADD R3=R1+R2.
        force_r0(16'h0005);
        issue(3, 0, 0, 1, td);
        wait_idle();
        force_r0(16'h0003);
        issue(3, 0, 0, 2, td);
        wait_idle();
        issue(0, 1, 2, 3, td);
        wait_idle();
        chk("add_result", result, 16'h0008);
        chk("add_flags", {flag_z, flag_n, flag_v}, 3'b000);
        chk("add_r3", rf_mem[3], 16'h0008);

        issue(1, 2, 1, 4, td);
        wait_idle();
        chk("sub_neg_result", result, 16'hFFFE);
        chk("sub_neg_flags", {flag_z, flag_n, flag_v}, 3'b010);

        force_r0(16'h7FFF);
        issue(3, 0, 0, 6, td);
        wait_idle();
        force_r0(16'h0001);
        issue(3, 0, 0, 7, td);
        wait_idle();
        issue(0, 6, 7, 3, td);
        wait_idle();
        chk("add_ovf_result", result, 16'h8000);
        chk("add_ovf_flags", {flag_z, flag_n, flag_v}, 3'b011);

        issue(1, 1, 1, 5, td);
        wait_idle();
        chk("sub_zero_result", result, 16'h0000);
        chk("sub_zero_flags", {flag_z, flag_n, flag_v}, 3'b100);

        force_r0(16'h00F0);
        issue(3, 0, 0, 6, td);
        wait_idle();
        force_r0(16'h0FF0);
        issue(3, 0, 0, 7, td);
        wait_idle();
        issue(2, 6, 7, 3, td);
        wait_idle();
        chk("and_result", result, 16'h00F0);
        chk("and_flags", {flag_z, flag_n, flag_v}, 3'b000);

        // MOV with a distinct rb: the monitor flags any read of R7.
        issue(3, 1, 7, 6, td);
        wait_idle();
        chk("mov_r6", rf_mem[6], 16'h0005);
        chk("mov_result", result, 16'h0005);

        // Back-to-back with valid held high, including aliased R1=R1+R1.
        issue(0, 1, 1, 1, t1);
        issue(1, 1, 2, 4, t2);
        issue(2, 1, 2, 5, t3);
        wait_idle();
        chk("b2b_spacing_1", t2 - t1, 4);
        chk("b2b_spacing_2", t3 - t2, 4);
        chk("alias_r1", rf_mem[1], 16'h000A);
        chk("b2b_r4", rf_mem[4], 16'h0007);
        chk("b2b_last_result", result, 16'h0002);

        // Reset landing on the WB cycle of ADD R7=R2+R2 must abandon the op.
        mon_en = 1'b0;
        req_op = 2'b00;
        req_ra = 3'd2;
        req_rb = 3'd2;
        req_rd = 3'd7;
        req_valid = 1'b1;
        @(negedge clk);
        chk("rstwb_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwb_nowrite", rf_write, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstwb_ready", req_ready, 1);
        chk("rstwb_nodone", done, 0);
        chk("rstwb_result", result, 0);
        chk("rstwb_r7", rf_mem[7], 16'h0FF0);
        @(negedge clk);
        chk("rstwb_nodone2", done, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Randomised traffic against the reference model.
        for (int k = 1; k < 8; k++) begin
            force_r0(pickval());
            issue(3, 0, int'($urandom_range(0, 7)), k, td);
            wait_idle();
        end
        force_r0(pickval());
        for (int k = 0; k < 60; k++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), td);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_idle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) chk("final_reg", rf_mem[i], ref_reg[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
